// File: rtl/psram_qpi_responder.sv
// psram_qpi_responder: emulates two x4 QPI PSRAM devices sharing one chip
// select (lane 0 on data[3:0], lane 1 on data[7:4]), each backed by an
// on-chip byte memory. Supports SPI-mode 35h (enter QPI), and QPI-mode
// EBh (read), 38h (write) and F5h (exit QPI).
// Optional macro PSRAM_RSP_ERR_EN builds the sticky protocol-error flag.
module psram_qpi_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 6
) (
   input  logic       arst_n,
   input  logic       i_clk,
   input  logic       i_psram_csn,
   input  logic [7:0] i_psram_data,
   output logic [7:0] o_psram_data,
   output logic [7:0] o_psram_oe,
   output logic       o_qpi,
   output logic       o_err
);

   localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_CMD     = 3'd0,
      S_ADDR    = 3'd1,
      S_WAIT    = 3'd2,
      S_RD_DATA = 3'd3,
      S_WR_DATA = 3'd4,
      S_IGNORE  = 3'd5
   } state_t;

   state_t        r_state;
   logic [3:0]    r_cnt;
   logic [6:0]    r_sh0;
   logic [AW-1:0] r_ptr;
   logic          r_is_write;
   logic          r_phase;
   logic [7:0]    r_hi;
   logic          r_pend_on;
   logic          r_pend_off;
   logic          r_qpi;
   logic [7:0]    r_oe;
   logic [7:0]    r_data;
   logic [7:0]    r_mem0 [0:DEPTH-1];
   logic [7:0]    r_mem1 [0:DEPTH-1];

   state_t        w_state_nxt;
   logic [3:0]    w_cnt_nxt;
   logic          w_phase_nxt;
   logic          w_is_write_nxt;
   logic [7:0]    w_oe_nxt;
   logic [7:0]    w_data_nxt;
   logic          w_ptr_shift;
   logic          w_ptr_inc;
   logic          w_we;
   logic          w_pend_on;
   logic          w_pend_off;

   wire [7:0]    w_spi_byte0   = {r_sh0[6:0], i_psram_data[0]};
   wire [7:0]    w_qpi_byte    = {r_sh0[3:0], i_psram_data[3:0]};
   wire [AW-1:0] w_ptr_shifted = AW'({r_ptr, i_psram_data[3:0]});
   wire [7:0]    w_rd0         = r_mem0[r_ptr];
   wire [7:0]    w_rd1         = r_mem1[r_ptr];

   // Next-state, bus output and datapath strobes; CS high overrides everything
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt + 4'd1;
      w_phase_nxt    = 1'b0;
      w_is_write_nxt = r_is_write;
      w_oe_nxt       = 8'h00;
      w_data_nxt     = 8'h00;
      w_ptr_shift    = 1'b0;
      w_ptr_inc      = 1'b0;
      w_we           = 1'b0;
      w_pend_on      = 1'b0;
      w_pend_off     = 1'b0;
      if (i_psram_csn) begin
         w_state_nxt = S_CMD;
         w_cnt_nxt   = 4'd0;
      end else begin
         case (r_state)
            S_CMD: begin
               if (!r_qpi && (r_cnt == 4'd7)) begin
                  w_cnt_nxt   = 4'd0;
                  w_state_nxt = S_IGNORE;
                  w_pend_on   = (w_spi_byte0 == 8'h35);
               end else if (r_qpi && (r_cnt == 4'd1)) begin
                  w_cnt_nxt = 4'd0;
                  case (w_qpi_byte)
                     8'hEB: begin
                        w_state_nxt    = S_ADDR;
                        w_is_write_nxt = 1'b0;
                     end
                     8'h38: begin
                        w_state_nxt    = S_ADDR;
                        w_is_write_nxt = 1'b1;
                     end
                     8'hF5: begin
                        w_state_nxt = S_IGNORE;
                        w_pend_off  = 1'b1;
                     end
                     default: w_state_nxt = S_IGNORE;
                  endcase
               end else begin
                  w_state_nxt = S_CMD;
               end
            end
            S_ADDR: begin
               w_ptr_shift = 1'b1;
               if (r_cnt == 4'd5) begin
                  w_cnt_nxt   = 4'd0;
                  w_state_nxt = r_is_write ? S_WR_DATA : S_WAIT;
               end else begin
                  w_state_nxt = S_ADDR;
               end
            end
            S_WAIT: begin
               if (r_cnt == WAIT_LAST) begin
                  w_cnt_nxt   = 4'd0;
                  w_state_nxt = S_RD_DATA;
                  w_oe_nxt    = 8'hFF;
                  w_data_nxt  = {w_rd1[7:4], w_rd0[7:4]};
                  w_phase_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end
            S_RD_DATA: begin
               w_oe_nxt    = 8'hFF;
               w_phase_nxt = ~r_phase;
               if (r_phase) begin
                  w_data_nxt = {w_rd1[3:0], w_rd0[3:0]};
                  w_ptr_inc  = 1'b1;
               end else begin
                  w_data_nxt = {w_rd1[7:4], w_rd0[7:4]};
               end
            end
            S_WR_DATA: begin
               w_phase_nxt = ~r_phase;
               if (r_phase) begin
                  w_we      = 1'b1;
                  w_ptr_inc = 1'b1;
               end else begin
                  w_we = 1'b0;
               end
            end
            S_IGNORE: w_state_nxt = S_IGNORE;
            default:  w_state_nxt = S_CMD;
         endcase
      end
   end

   // Control registers, shifters and registered bus outputs
   always_ff @(posedge i_clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state    <= S_CMD;
         r_cnt      <= 4'd0;
         r_sh0      <= 7'd0;
         r_ptr      <= '0;
         r_is_write <= 1'b0;
         r_phase    <= 1'b0;
         r_hi       <= 8'h00;
         r_pend_on  <= 1'b0;
         r_pend_off <= 1'b0;
         r_qpi      <= 1'b0;
         r_oe       <= 8'h00;
         r_data     <= 8'h00;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_is_write <= w_is_write_nxt;
         r_phase    <= w_phase_nxt;
         r_oe       <= w_oe_nxt;
         r_data     <= w_data_nxt;
         r_pend_on  <= !i_psram_csn && (r_pend_on || w_pend_on);
         r_pend_off <= !i_psram_csn && (r_pend_off || w_pend_off);
         if (!i_psram_csn && (r_state == S_CMD)) begin
            r_sh0 <= r_qpi ? {r_sh0[2:0], i_psram_data[3:0]} : {r_sh0[5:0], i_psram_data[0]};
         end
         if (!i_psram_csn && (r_state == S_WR_DATA) && !r_phase) begin
            r_hi <= i_psram_data;
         end
         if (w_ptr_shift) begin
            r_ptr <= w_ptr_shifted;
         end else if (w_ptr_inc) begin
            r_ptr <= r_ptr + AW'(1);
         end
         if (i_psram_csn) begin
            if (r_pend_on) begin
               r_qpi <= 1'b1;
            end else if (r_pend_off) begin
               r_qpi <= 1'b0;
            end
         end
      end
   end

   // Lane memories: one write port each, read combinationally at r_ptr
   always_ff @(posedge i_clk) begin
      if (w_we) begin
         r_mem0[r_ptr] <= {r_hi[3:0], i_psram_data[3:0]};
         r_mem1[r_ptr] <= {r_hi[7:4], i_psram_data[7:4]};
      end
   end

`ifdef PSRAM_RSP_ERR_EN
   logic [6:0] r_sh1;
   logic       r_err;
   logic       w_err_set;
   wire [7:0]  w_spi_byte1 = {r_sh1[6:0], i_psram_data[4]};

   // Protocol error detection: aborted command/address, partial write byte, bad command
   always_comb begin
      w_err_set = 1'b0;
      if (i_psram_csn) begin
         w_err_set = ((r_state == S_CMD) && (r_cnt != 4'd0)) || (r_state == S_ADDR) ||
                     ((r_state == S_WR_DATA) && r_phase);
      end else if ((r_state == S_CMD) && !r_qpi && (r_cnt == 4'd7)) begin
         w_err_set = (w_spi_byte0 != w_spi_byte1) || (w_spi_byte0 != 8'h35);
      end else if ((r_state == S_CMD) && r_qpi && (r_cnt == 4'd1)) begin
         w_err_set = !((w_qpi_byte == 8'hEB) || (w_qpi_byte == 8'h38) || (w_qpi_byte == 8'hF5));
      end else begin
         w_err_set = 1'b0;
      end
   end

   // Lane 1 SPI command shifter and sticky error flag
   always_ff @(posedge i_clk or negedge arst_n) begin
      if (!arst_n) begin
         r_sh1 <= 7'd0;
         r_err <= 1'b0;
      end else begin
         if (!i_psram_csn && (r_state == S_CMD) && !r_qpi) begin
            r_sh1 <= {r_sh1[5:0], i_psram_data[4]};
         end
         r_err <= r_err | w_err_set;
      end
   end

   assign o_err = r_err;
`else
   assign o_err = 1'b0;
`endif

   assign o_psram_data = r_data;
   assign o_psram_oe   = r_oe;
   assign o_qpi        = r_qpi;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed bench for psram_qpi_responder (DEPTH=1024, WAIT_CYCLES=6).
module tb_psram_qpi_responder;

   localparam int DEPTH = 1024;
`ifdef PSRAM_RSP_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic       csn = 1'b1;
   logic [7:0] din = 8'h00;
   logic [7:0] o_data;
   logic [7:0] o_oe;
   logic       o_qpi;
   logic       o_err;

   int n_total = 0;
   int n_pass  = 0;
   logic [7:0] oe_acc;
   logic       tim_ok;
   logic [7:0] rd_hi [16];
   logic [7:0] rd_lo [16];
   logic [7:0] wr_hi [16];
   logic [7:0] wr_lo [16];

   typedef struct {
      logic [23:0] addr;
      logic [7:0]  bus_hi;
      logic [7:0]  bus_lo;
      logic [7:0]  exp_l0;
      logic [7:0]  exp_l1;
   } vec_t;
   vec_t vecs [4];

   psram_qpi_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(6)) dut (
      .arst_n      (arst_n),
      .i_clk       (clk),
      .i_psram_csn (csn),
      .i_psram_data(din),
      .o_psram_data(o_data),
      .o_psram_oe  (o_oe),
      .o_qpi       (o_qpi),
      .o_err       (o_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // One bus clock: drive on the falling edge, return 1 ns after the rising edge
   task automatic bus_edge(input logic c, input logic [7:0] d);
      @(negedge clk);
      csn = c;
      din = d;
      @(posedge clk);
      #1;
      oe_acc = oe_acc | o_oe;
   endtask

   task automatic cs_high();
      bus_edge(1'b1, 8'h00);
   endtask

   task automatic spi_cmd(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) bus_edge(1'b0, {3'b000, b[i], 3'b000, b[i]});
   endtask

   task automatic qpi_byte(input logic [7:0] b);
      bus_edge(1'b0, {4'h0, b[7:4]});
      bus_edge(1'b0, {4'h0, b[3:0]});
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 5; i >= 0; i--) bus_edge(1'b0, {4'h0, a[i*4 +: 4]});
   endtask

   task automatic do_write(input logic [23:0] a, input int n);
      qpi_byte(8'h38);
      send_addr(a);
      for (int i = 0; i < n; i++) begin
         bus_edge(1'b0, wr_hi[i]);
         bus_edge(1'b0, wr_lo[i]);
      end
      cs_high();
   endtask

   // Read burst; tim_ok clears if oe is wrong on any dummy, data or CS-high edge
   task automatic do_read(input logic [23:0] a, input int n);
      tim_ok = 1'b1;
      qpi_byte(8'hEB);
      send_addr(a);
      for (int k = 1; k <= 5; k++) begin
         bus_edge(1'b0, 8'h00);
         if (o_oe !== 8'h00) tim_ok = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         bus_edge(1'b0, 8'h00);
         if (o_oe !== 8'hFF) tim_ok = 1'b0;
         rd_hi[i] = o_data;
         bus_edge(1'b0, 8'h00);
         if (o_oe !== 8'hFF) tim_ok = 1'b0;
         rd_lo[i] = o_data;
      end
      cs_high();
      if (o_oe !== 8'h00) tim_ok = 1'b0;
   endtask

   initial begin
      vecs[0] = '{addr: 24'h000010, bus_hi: 8'h5A, bus_lo: 8'hC3, exp_l0: 8'hA3, exp_l1: 8'h5C};
      vecs[1] = '{addr: 24'h000123, bus_hi: 8'h12, bus_lo: 8'h34, exp_l0: 8'h24, exp_l1: 8'h13};
      vecs[2] = '{addr: 24'hABC3FF, bus_hi: 8'hF0, bus_lo: 8'h0F, exp_l0: 8'h0F, exp_l1: 8'hF0};
      vecs[3] = '{addr: 24'h000400, bus_hi: 8'h9E, bus_lo: 8'h7B, exp_l0: 8'hEB, exp_l1: 8'h97};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_oe", {24'd0, o_oe}, 32'h0);
      chk("reset_data", {24'd0, o_data}, 32'h0);
      chk("reset_qpi", {31'd0, o_qpi}, 32'h0);
      chk("reset_err", {31'd0, o_err}, 32'h0);
      @(negedge clk);
      arst_n = 1'b1;

      // SPI 35h: QPI only after CS rises, oe never driven
      oe_acc = 8'h00;
      spi_cmd(8'h35);
      chk("qpi_before_cs", {31'd0, o_qpi}, 32'h0);
      cs_high();
      chk("qpi_enter", {31'd0, o_qpi}, 32'h1);
      chk("spi_oe_idle", {24'd0, oe_acc}, 32'h0);

      // Table: single-byte writes, then readback with lane mapping check
      for (int v = 0; v < 4; v++) begin
         wr_hi[0] = vecs[v].bus_hi;
         wr_lo[0] = vecs[v].bus_lo;
         do_write(vecs[v].addr, 1);
      end
      for (int v = 0; v < 4; v++) begin
         do_read(vecs[v].addr, 1);
         chk($sformatf("tbl%0d_hi", v), {24'd0, rd_hi[0]}, {24'd0, vecs[v].exp_l1[7:4], vecs[v].exp_l0[7:4]});
         chk($sformatf("tbl%0d_lo", v), {24'd0, rd_lo[0]}, {24'd0, vecs[v].exp_l1[3:0], vecs[v].exp_l0[3:0]});
         chk($sformatf("tbl%0d_timing", v), {31'd0, tim_ok}, 32'h1);
      end
      chk("err_clean", {31'd0, o_err}, 32'h0);

      // Burst write across the end of memory, readback as one burst
      for (int i = 0; i < 4; i++) begin
         wr_hi[i] = 8'h11 + 8'(i * 8'h22);
         wr_lo[i] = 8'h22 + 8'(i * 8'h22);
      end
      do_write(24'(DEPTH - 2), 4);
      do_read(24'(DEPTH - 2), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("burst%0d_hi", i), {24'd0, rd_hi[i]}, {24'd0, wr_hi[i]});
         chk($sformatf("burst%0d_lo", i), {24'd0, rd_lo[i]}, {24'd0, wr_lo[i]});
      end
      do_read(24'h000000, 1);
      chk("wrap0", {16'd0, rd_hi[0], rd_lo[0]}, 32'h5566);
      do_read(24'h000001, 1);
      chk("wrap1", {16'd0, rd_hi[0], rd_lo[0]}, 32'h7788);

      // Aborted address phase, then a valid read
      qpi_byte(8'hEB);
      bus_edge(1'b0, 8'h00);
      bus_edge(1'b0, 8'h00);
      bus_edge(1'b0, 8'h00);
      cs_high();
      chk("abort_oe", {24'd0, o_oe}, 32'h0);
      chk("abort_err", {31'd0, o_err}, {31'd0, EXP_ERR});
      do_read(24'h000010, 1);
      chk("after_abort", {16'd0, rd_hi[0], rd_lo[0]}, 32'h5AC3);
      chk("after_abort_timing", {31'd0, tim_ok}, 32'h1);

      // CS rises on the low-nibble edge: byte must not be committed
      qpi_byte(8'h38);
      send_addr(24'h000123);
      bus_edge(1'b0, 8'hAB);
      bus_edge(1'b1, 8'hCD);
      do_read(24'h000123, 1);
      chk("partial_wr", {16'd0, rd_hi[0], rd_lo[0]}, 32'h1234);

      // QPI exit and re-entry
      qpi_byte(8'hF5);
      chk("qpi_exit_pending", {31'd0, o_qpi}, 32'h1);
      cs_high();
      chk("qpi_exit", {31'd0, o_qpi}, 32'h0);
      spi_cmd(8'h35);
      cs_high();
      chk("qpi_reenter", {31'd0, o_qpi}, 32'h1);

      // Async reset in the middle of a read burst
      qpi_byte(8'hEB);
      send_addr(24'h000010);
      for (int k = 0; k < 7; k++) bus_edge(1'b0, 8'h00);
      chk("pre_rst_oe", {24'd0, o_oe}, 32'hFF);
      #1;
      arst_n = 1'b0;
      #1;
      chk("rst_oe", {24'd0, o_oe}, 32'h0);
      chk("rst_qpi", {31'd0, o_qpi}, 32'h0);
      chk("rst_err", {31'd0, o_err}, 32'h0);
      cs_high();
      @(negedge clk);
      arst_n = 1'b1;

      // QPI read while back in SPI mode is ignored
      oe_acc = 8'h00;
      qpi_byte(8'hEB);
      send_addr(24'h000010);
      for (int k = 0; k < 10; k++) bus_edge(1'b0, 8'h00);
      cs_high();
      chk("spi_ignore_oe", {24'd0, oe_acc}, 32'h0);
      chk("spi_ignore_qpi", {31'd0, o_qpi}, 32'h0);

      // Re-enter QPI; memory survived reset
      spi_cmd(8'h35);
      cs_high();
      do_read(24'h000010, 1);
      chk("post_rst_read", {16'd0, rd_hi[0], rd_lo[0]}, 32'h5AC3);
      chk("post_rst_timing", {31'd0, tim_ok}, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
